// File: rtl/alu_bist.sv
// Built-in self-test driver for the 8-bit combinational alu.
// Operands come from an LFSR; results are folded into a 16-bit MISR.
module alu_bist #(
  parameter int unsigned NUM_VECTORS = 32,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [15:0] EXP_SIG     = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_mode,
  input  logic [7:0]  alu_result,
  input  logic        alu_cout,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] LAST = 16'(NUM_VECTORS - 1);

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] misr_q, misr_d;
  logic [15:0] cnt_q, cnt_d;

  logic [15:0] lfsr_step;
  logic [15:0] misr_step;

  // x^16+x^14+x^13+x^11+1, Fibonacci form
  assign lfsr_step = {lfsr_q[14:0],
                      lfsr_q[15] ^ lfsr_q[13] ^
                      lfsr_q[12] ^ lfsr_q[10]};

  assign misr_step = {misr_q[14:0], 1'b0}
                   ^ (misr_q[15] ? 16'h8005 : 16'h0000)
                   ^ {7'b0, alu_cout, alu_result};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      misr_q  <= 16'h0000;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          lfsr_d  = LFSR_SEED;
          misr_d  = 16'h0000;
          cnt_d   = 16'h0000;
        end
      end
      RUN: begin
        misr_d = misr_step;
        // last vector leaves operands frozen on display
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          lfsr_d = lfsr_step;
          cnt_d  = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign alu_a     = lfsr_q[15:8];
  assign alu_b     = lfsr_q[7:0];
  assign alu_mode  = cnt_q[3:0];
  assign signature = misr_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = (state_q == DONE) && (misr_q == EXP_SIG);

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist: three instances with 1, 2 and 32 vectors,
// each driving a stub or reference alu model.
module tb_alu_bist;

  logic clk = 1'b0;
  logic reset;
  logic start1, start2, start32;

  always #5 clk = ~clk;

  logic [7:0]  a1, b1, a2, b2, a32, b32;
  logic [3:0]  m1, m2, m32;
  logic [7:0]  r1, r2, r32;
  logic        c32;
  logic        busy1, done1, pass1;
  logic        busy2, done2, pass2;
  logic        busy32, done32, pass32;
  logic [15:0] sig1, sig2, sig32;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [8:0] alu_ref(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [3:0] op
  );
    logic [8:0] r;
    case (op[1:0])
      2'd0:    r = {1'b0, a} + {1'b0, b};
      2'd1:    r = {1'b0, a} - {1'b0, b};
      2'd2:    r = {op[3], a ^ b};
      default: r = {a[7], a[6:0], op[2]};
    endcase
    return r;
  endfunction

  assign r1 = a1 ^ b1;
  assign r2 = a2 ^ b2;
  assign {c32, r32} = alu_ref(a32, b32, m32);

  alu_bist #(.NUM_VECTORS(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .alu_a(a1), .alu_b(b1), .alu_mode(m1),
    .alu_result(r1), .alu_cout(1'b0),
    .busy(busy1), .done(done1), .pass(pass1),
    .signature(sig1)
  );

  alu_bist #(.NUM_VECTORS(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2),
    .alu_a(a2), .alu_b(b2), .alu_mode(m2),
    .alu_result(r2), .alu_cout(1'b0),
    .busy(busy2), .done(done2), .pass(pass2),
    .signature(sig2)
  );

  alu_bist #(.NUM_VECTORS(32)) u_dut32 (
    .clk(clk), .reset(reset), .start(start32),
    .alu_a(a32), .alu_b(b32), .alu_mode(m32),
    .alu_result(r32), .alu_cout(c32),
    .busy(busy32), .done(done32), .pass(pass32),
    .signature(sig32)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle32(input string tag);
    chk({tag, ".a"}, 32'(a32), 32'hAC);
    chk({tag, ".b"}, 32'(b32), 32'hE1);
    chk({tag, ".mode"}, 32'(m32), 32'h0);
    chk({tag, ".sig"}, 32'(sig32), 32'h0);
    chk({tag, ".flags"}, {busy32, done32, pass32}, 32'h0);
  endtask

  logic [15:0] clean_sig;

  // Drives one 32-vector run; poke = vector index for a stray start,
  // rst_at = vector index where reset+start abort the run (-1 = none).
  task automatic run32(
    input  int          poke,
    input  int          rst_at,
    output logic [15:0] sig_out
  );
    logic [15:0] l, m;
    logic [8:0]  r;
    logic [3:0]  op;
    l = 16'hACE1;
    m = 16'h0000;
    sig_out = 16'hxxxx;
    start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    for (int k = 0; k < 32; k++) begin
      op = 4'(k);
      chk($sformatf("busy32[%0d]", k), 32'(busy32), 32'h1);
      chk($sformatf("done32[%0d]", k), 32'(done32), 32'h0);
      chk($sformatf("a32[%0d]", k), 32'(a32), 32'(l[15:8]));
      chk($sformatf("b32[%0d]", k), 32'(b32), 32'(l[7:0]));
      chk($sformatf("mode32[%0d]", k), 32'(m32), 32'(op));
      if (k == rst_at) begin
        reset   = 1'b1;
        start32 = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        start32 = 1'b0;
        chk_idle32("midrst");
        @(negedge clk);
        chk_idle32("midrst_hold");
        return;
      end
      start32 = (k == poke);
      r = alu_ref(l[15:8], l[7:0], op);
      m = {m[14:0], 1'b0} ^ (m[15] ? 16'h8005 : 16'h0000)
        ^ {7'b0, r};
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      @(negedge clk);
      start32 = 1'b0;
    end
    chk("done32_end", 32'(done32), 32'h1);
    chk("busy32_end", 32'(busy32), 32'h0);
    chk("sig32", 32'(sig32), 32'(m));
    chk("pass32", 32'(pass32), 32'(m == 16'h0000));
    sig_out = m;
  endtask

  initial begin
    logic [15:0] s;
    reset   = 1'b1;
    start1  = 1'b0;
    start2  = 1'b0;
    start32 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    chk("rst.a", 32'(a1), 32'hAC);
    chk("rst.b", 32'(b1), 32'hE1);
    chk("rst.mode", 32'(m1), 32'h0);
    chk("rst.sig", 32'(sig1), 32'h0);
    chk("rst.flags", {busy1, done1, pass1}, 32'h0);
    chk_idle32("rst32");

    // single vector
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("v1.busy", 32'(busy1), 32'h1);
    chk("v1.ab", {a1, b1}, 32'hACE1);
    chk("v1.mode", 32'(m1), 32'h0);
    @(negedge clk);
    chk("v1.busy_end", 32'(busy1), 32'h0);
    chk("v1.done", 32'(done1), 32'h1);
    chk("v1.sig", 32'(sig1), 32'h004D);
    chk("v1.pass", 32'(pass1), 32'h0);
    repeat (3) @(negedge clk);
    chk("v1.hold_done", 32'(done1), 32'h1);
    chk("v1.hold_sig", 32'(sig1), 32'h004D);

    // two vectors, signature cancels to zero
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("v2.k0", {busy2, a2, b2, m2}, {1'b1, 16'hACE1, 4'd0});
    @(negedge clk);
    chk("v2.k1", {busy2, a2, b2, m2}, {1'b1, 16'h59C3, 4'd1});
    @(negedge clk);
    chk("v2.done", {busy2, done2}, 32'h1);
    chk("v2.sig", 32'(sig2), 32'h0000);
    chk("v2.pass", 32'(pass2), 32'h1);

    // full sweep, then stray start, then abort and reruns
    run32(-1, -1, clean_sig);
    run32(5, -1, s);
    chk("poke_same", 32'(s), 32'(clean_sig));
    run32(-1, 10, s);
    run32(-1, -1, s);
    chk("after_rst_same", 32'(s), 32'(clean_sig));
    run32(-1, -1, s);
    chk("rerun_same", 32'(s), 32'(clean_sig));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_bist.md
# alu_bist

Built-in self-test controller for the 8-bit combinational `alu`. It owns the initiator side of the ALU interface: it generates operands from a 16-bit LFSR and sweeps opcodes from a counter. Each cycle it compresses the ALU result and carry into a 16-bit MISR signature, then compares the final signature against an expected value. It sits beside the ALU and replaces an external stimulus driver for in-system checking.

## Interface
- `NUM_VECTORS`, 32: number of vectors applied per run; legal range 1..65535.
- `LFSR_SEED`, 16'hACE1: operand LFSR load value. Must be non-zero.
- `EXP_SIG`, 16'h0000: golden MISR signature; `pass` compares against it.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: run request, sampled each edge. Honoured in IDLE and DONE, ignored in RUN.
- `alu_a` output 8: ALU operand A = `lfsr[15:8]`.
- `alu_b` output 8: ALU operand B = `lfsr[7:0]`.
- `alu_mode` output 4: ALU opcode = `vec_cnt[3:0]`.
- `alu_result` input 8: ALU output, sampled combinationally in the same cycle.
- `alu_cout` input 1: ALU carry out, sampled with `alu_result`.
- `busy` output 1: high in RUN.
- `done` output 1: high in DONE.
- `pass` output 1: in DONE, equals (`signature == EXP_SIG`); 0 otherwise.
- `signature` output 16: current MISR value.

## Operation
- **FSM states.** IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE after `NUM_VECTORS` absorptions.
  - DONE → RUN on `start`; otherwise DONE holds indefinitely.
- **Run initialisation.** On any accepted `start`: `lfsr` ← `LFSR_SEED`, `misr` ← 0, `vec_cnt` ← 0.
- **Operand LFSR.** Fibonacci, x^16+x^14+x^13+x^11+1.
  - fb = `lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]`.
  - next = {`lfsr[14:0]`, fb}.
- **Per-edge action in RUN.**
  - `misr` ← ({`misr[14:0]`,0} ^ (`misr[15]` ? 16'h8005 : 0)) ^ {7'b0, `alu_cout`, `alu_result`}.
  - `lfsr` steps once.
  - `vec_cnt` increments.
  - On the edge where `vec_cnt == NUM_VECTORS-1`: absorb, then go to DONE. `lfsr` and `vec_cnt` freeze from that point.
- **Opcode sweep.** `alu_mode` wraps 15→0 naturally via `vec_cnt[3:0]`. `vec_cnt` is 16 bits.
- **Frozen state.** In IDLE and DONE, `lfsr`, `misr` and `vec_cnt` hold their values. `alu_*` outputs therefore stay stable.
- **Reset values.**
  - state = IDLE.
  - `lfsr` = `LFSR_SEED`, so `alu_a`/`alu_b` = seed bytes.
  - `vec_cnt` = 0, `alu_mode` = 0.
  - `misr` = 0, `signature` = 0.
  - `busy` = `done` = `pass` = 0.
- **Reset mid-RUN.** Aborts the run; all state returns to reset values on that edge. A `start` on the same edge is ignored.

## Timing
- `start` sampled at edge E0 puts the block in RUN from E0.
  - Vector k (k = 0..N-1) is driven during the cycle after edge E0+k.
  - Vector k is absorbed at edge E0+k+1.
- `done` rises after edge E0+N: N cycles of `busy` from `start` to `done`.
- **ALU path.** The ALU is combinational; `alu_*` outputs come straight from registers. The full path registers → alu → misr must close in one cycle. There is no pipeline.
- **Outputs.** `busy`, `done` and `pass` are decoded from registered state and are glitch-free. `pass` is valid in the same cycle as `done`.
- **Restart from DONE.** `start` in DONE re-runs; `done` drops at the next edge.

## Test plan
- **Reset.** Assert `reset` for 2 cycles → `alu_a`=8'hAC, `alu_b`=8'hE1, `alu_mode`=0, `signature`=0, and `busy`/`done`/`pass`=0.
- **Single vector.** Bench stub ALU: `alu_result`=`alu_a^alu_b`, `alu_cout`=0. With `NUM_VECTORS`=1, pulse `start` → `busy` high for 1 cycle with a=AC, b=E1, mode=0. Then `done`=1 and `signature`=16'h004D; `pass`=0 with `EXP_SIG`=0.
- **Two vectors, pass.** Same stub, `NUM_VECTORS`=2 → second vector a=59, b=C3, mode=1. Final `signature`=16'h0000, `pass`=1.
- **Full sweep.** `NUM_VECTORS`=32 with a bench reference model of the ALU, `alu_cout` toggling → `alu_mode` sequence is 0..15,0..15. Operands match a software LFSR. `signature` matches the software MISR; `done` arrives exactly 32 cycles after `start`.
- **Start during RUN.** Pulse `start` at vector 5 of 32 → ignored. Result is identical to the undisturbed run.
- **Reset mid-run, then restart.** Assert `reset` at vector 10 together with `start` → block in IDLE with reset values. A later `start` reproduces the clean-run signature. A further `start` in DONE re-runs and yields the same signature.
